// File: rtl/prog_sequencer.sv
// prog_sequencer: walks program memory from address 0 on start, buffers returned
// words in a 2-entry FIFO and hands them to fetch as rd/data_out until HALT, end or abort.
module prog_sequencer #(
    parameter int DATA_LEN = 16,
    parameter int ADDR_W = 8,
    parameter int PROG_LEN = 256,
    parameter logic [DATA_LEN-1:0] HALT_WORD = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                ready,
    input  logic                computation_end,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                rd,
    output logic [DATA_LEN-1:0] data_out,
    output logic                busy,
    output logic                done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_LEN-1:0] f0_q, f0_d, f1_q, f1_d, dout_q, dout_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                infl_q, infl_d, rd_q, rd_d;
    logic                active, halt_ret, push, pop, issue;
    logic [1:0]          occ;

    always_comb begin
        active   = state_q == S_RUN || state_q == S_DRAIN;
        halt_ret = infl_q && mem_rdata == HALT_WORD;
        pop      = active && !computation_end && cnt_q != 2'd0 && ready;
        push     = active && !computation_end && infl_q && !halt_ret;
        occ      = cnt_q + 2'(infl_q) - 2'(pop);
        // a returning HALT suppresses issue in the same cycle, so nothing follows it
        issue    = state_q == S_RUN && !computation_end && !halt_ret && occ < 2'd2;
        pc_d     = issue ? (pc_q == LAST ? pc_q : pc_q + ADDR_W'(1)) : pc_q;
        infl_d   = issue;
        rd_d     = pop;
        dout_d   = pop ? f0_q : dout_q;
        f0_d     = pop ? f1_q : f0_q;
        f1_d     = f1_q;
        if (push && cnt_q - 2'(pop) == 2'd0)
            f0_d = mem_rdata;
        else if (push)
            f1_d = mem_rdata;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        state_d  = state_q;
        if (!active && start) begin
            state_d = S_RUN;
            pc_d    = '0;
            cnt_d   = 2'd0;
            infl_d  = 1'b0;
        end else if (active && computation_end) begin
            state_d = S_DONE;
            cnt_d   = 2'd0;
            infl_d  = 1'b0;
        end else if (state_q == S_RUN && ((issue && pc_q == LAST) || halt_ret))
            state_d = S_DRAIN;
        else if (state_q == S_DRAIN && cnt_q == 2'd0 && !infl_q && !pop)
            state_d = S_DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            f0_q    <= '0;
            f1_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= 2'd0;
            infl_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            infl_q  <= infl_d;
            rd_q    <= rd_d;
        end
    end

    assign mem_en   = issue;
    assign mem_addr = pc_q;
    assign rd       = rd_q;
    assign data_out = dout_q;
    assign busy     = active;
    assign done     = state_q == S_DONE;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed checks of prog_sequencer with a synchronous program
// memory model; a second instance runs with a 4-word program space.
module tb_prog_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, ready = 1'b1, comp = 1'b0;
    logic        mem_en, rd, busy, done;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata, data_out;
    logic        start4 = 1'b0, ready4 = 1'b1, comp4 = 1'b0;
    logic        mem_en4, rd4, busy4, done4;
    logic [7:0]  mem_addr4;
    logic [15:0] mem_rdata4, data_out4;
    logic [15:0] mem [256];
    logic [15:0] mem4 [256];
    int          cyc = 0, t0 = 0, tests = 0, fails = 0, max_addr4 = 0;
    logic [15:0] words[$], words4[$];
    int          rd_cyc[$], addrs[$], addrs4[$];

    prog_sequencer u0 (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .computation_end(comp),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rd(rd), .data_out(data_out), .busy(busy), .done(done)
    );
    prog_sequencer #(.PROG_LEN(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .ready(ready4), .computation_end(comp4),
        .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
        .rd(rd4), .data_out(data_out4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (mem_en4) mem_rdata4 <= mem4[mem_addr4];
    always @(negedge clk) begin
        if (rd) begin
            words.push_back(data_out);
            rd_cyc.push_back(cyc);
        end
        if (mem_en) addrs.push_back(int'(mem_addr));
        if (rd4) words4.push_back(data_out4);
        if (mem_en4) begin
            addrs4.push_back(int'(mem_addr4));
            if (int'(mem_addr4) > max_addr4) max_addr4 = int'(mem_addr4);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go();
        words.delete();
        rd_cyc.delete();
        addrs.delete();
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !done; i++) tick(1);
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_rd"}, 32'(rd), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h1234;
            mem4[i] = 16'h5555;
        end
        mem[0] = 16'h8001; mem[1] = 16'h4002; mem[2] = 16'h2003; mem[3] = 16'hFFFF;
        mem4[0] = 16'h0001; mem4[1] = 16'h0002; mem4[2] = 16'h0003; mem4[3] = 16'h0004;
        #2 rst = 1'b0;
        #1 check_reset_outs("rst0");
        #9 rst = 1'b1;
        tick(2);

        // basic run: 3 words then HALT
        go();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_addr", {31'd0, mem_en} << 8 | 32'(mem_addr), 32'h100);
        wait_done("t1_done");
        check("t1_nwords", words.size(), 3);
        check("t1_w0", 32'(words[0]), 32'h8001);
        check("t1_w1", 32'(words[1]), 32'h4002);
        check("t1_w2", 32'(words[2]), 32'h2003);
        for (int i = 0; i < 3; i++) check("t1_rd_cycle", rd_cyc[i], t0 + 4 + i);
        for (int i = 0; i < 4; i++) check("t1_addr", addrs[i], i);
        check("t1_naddr_le5", 32'(addrs.size() <= 5), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        tick(3);
        check("t1_done_held", 32'(done), 32'd1);

        // stall for 5 cycles after the first word
        go();
        tick(3);
        check("t2_first_rd", 32'(rd), 32'd1);
        check("t2_first_word", 32'(data_out), 32'h8001);
        ready = 1'b0;
        tick(2);
        check("t2_stall_mem_en", 32'(mem_en), 32'd0);
        check("t2_stall_rd", 32'(rd), 32'd0);
        tick(3);
        check("t2_stall_mem_en2", 32'(mem_en), 32'd0);
        check("t2_stall_held", 32'(data_out), 32'h8001);
        ready = 1'b1;
        tick(1);
        check("t2_resume_rd", 32'(rd), 32'd1);
        check("t2_resume_word", 32'(data_out), 32'h4002);
        wait_done("t2_done");
        check("t2_nwords", words.size(), 3);
        check("t2_w2", 32'(words[2]), 32'h2003);

        // end of a 4-word program space without HALT
        start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        for (int i = 0; i < 40 && !done4; i++) tick(1);
        check("t3_done", 32'(done4), 32'd1);
        check("t3_nwords", words4.size(), 4);
        for (int i = 0; i < 4; i++) check("t3_word", 32'(words4[i]), 32'(i + 1));
        check("t3_naddr", addrs4.size(), 4);
        check("t3_max_addr", max_addr4, 3);

        // abort after the second word of a 10-word program
        for (int i = 0; i < 10; i++) mem[i] = 16'h0100 + 16'(i);
        mem[10] = 16'hFFFF;
        go();
        tick(4);
        check("t4_second_rd", 32'(data_out), 32'h0101);
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        check("t4_rd_off", 32'(rd), 32'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_mem_en", 32'(mem_en), 32'd0);
        tick(5);
        check("t4_nwords", words.size(), 2);
        check("t4_rd_still_off", 32'(rd), 32'd0);

        // reset mid-run with two words buffered
        ready = 1'b0;
        go();
        tick(3);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1 check_reset_outs("t5_rst");
        #1 rst = 1'b1;
        ready = 1'b1;
        tick(1);
        go();
        wait_done("t5_done");
        check("t5_nwords", words.size(), 10);
        check("t5_w0", 32'(words[0]), 32'h0100);
        check("t5_w9", 32'(words[9]), 32'h0109);
        check("t5_first_rd_cycle", rd_cyc[0], t0 + 4);
        check("t5_addr0", addrs[0], 0);

        // start pulse during RUN is ignored
        go();
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("t6_done");
        check("t6_nwords", words.size(), 10);
        for (int i = 0; i < 10; i++) check("t6_word", 32'(words[i]), 32'h0100 + 32'(i));
        for (int i = 0; i < 11; i++) check("t6_addr", addrs[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
